csr_access_ctrl: RTL and testbench
==================================

CSR_ACCESS_CTRL -- requirements
Module: csr_access_ctrl

Interface
REQ-001 SHALL have one clock Clk and a synchronous, active-high reset Reset; all state changes on rising Clk.
REQ-002 Clk  in  1  system clock.
REQ-003 Reset  in  1  synchronous active-high reset.
REQ-004 Start  in  1  one-cycle request to execute a CSR instruction; sampled only in IDLE.
REQ-005 Funct3  in  3  SYSTEM funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI).
REQ-006 InstAddr  in  12  CSR address field of the instruction.
REQ-007 Rs1Index  in  5  rs1 index, or uimm for immediate forms.
REQ-008 Rs1Value  in  32  rs1 register value.
REQ-009 RdIndex  in  5  destination register index.
REQ-010 Flush  in  1  abort the in-flight access (interrupt entry or pipeline flush).
REQ-011 Busy  out  1  high in every state except IDLE.
REQ-012 Done  out  1  one-cycle completion pulse.
REQ-013 Illegal  out  1  one-cycle pulse, coincident with Done, marking an illegal CSR instruction.
REQ-014 RdWe  out  1  one-cycle register-file write enable, coincident with Done.
REQ-015 RdValue  out  32  old CSR value; valid while RdWe=1.
REQ-016 CsrEn  out  1  one-cycle start pulse to the CSR file.
REQ-017 CsrOp  out  5  CSR file op: [4] imm, [3:2] main op (01 WR, 10 SET, 11 CLEAR), [1:0] (00 read+write, 01 write-only, 10 read-only).
REQ-018 CsrAddr  out  12  CSR address; held from ISSUE until return to IDLE.
REQ-019 CsrData  out  32  operand to the CSR file; held like CsrAddr.
REQ-020 CsrRdata  in  32  value returned by the CSR file.

Function
REQ-021 States SHALL be IDLE, ISSUE, MODIFY, WRITE and FINISH.
REQ-022 IDLE with Start=1 and Flush=0 SHALL latch all instruction inputs and decode them.
  - Legal: go to ISSUE.
  - Illegal: go directly to FINISH with Illegal=1.
REQ-023 Main op SHALL come from Funct3[1:0] (01 WR, 10 SET, 11 CLEAR); CsrOp[4] SHALL equal Funct3[2].
REQ-024 CsrData SHALL be Rs1Value for register forms and {27'b0, Rs1Index} for immediate forms.
REQ-025 Read/write qualifier (CsrOp[1:0]):
  - RW/RWI with RdIndex=0: 01 (write-only).
  - RS/RC/RSI/RCI with Rs1Index=0: 10 (read-only).
  - Otherwise: 00.
REQ-026 Illegal conditions:
  - Funct3 of 000 or 100.
  - InstAddr[11:10]=11 with a write qualifier (00 or 01).
  - InstAddr[9:8]=10 (reserved privilege).
REQ-027 ISSUE SHALL assert CsrEn for exactly one cycle, then go to MODIFY.
REQ-028 MODIFY SHALL capture CsrRdata into RdValue, then:
  - go to WRITE if the qualifier is 00 or 01;
  - go to FINISH if it is 10.
REQ-029 WRITE SHALL last one cycle, then go to FINISH.
REQ-030 FINISH SHALL pulse Done, then go to IDLE.
  - RdWe=1 only if the access was legal, the qualifier is not 01, and RdIndex is not 0.
REQ-031 Latency from the Start cycle to Done:
  - read-only: 3 cycles;
  - writing access: 4 cycles;
  - illegal: 1 cycle.
REQ-032 Start while Busy SHALL be ignored; no request queuing.
REQ-033 Flush in ISSUE, MODIFY or FINISH SHALL return to IDLE next cycle with no Done, RdWe or Illegal.
REQ-034 Flush in WRITE SHALL still complete the write cycle but suppress Done and RdWe.
REQ-035 Flush and Start together in IDLE SHALL ignore Start.
REQ-036 CsrAddr and CsrData SHALL stay stable from ISSUE through WRITE.

Reset
REQ-037 Reset SHALL force IDLE and drive to 0: Busy, Done, Illegal, RdWe, CsrEn, RdValue, CsrOp, CsrAddr and CsrData.
REQ-038 Reset mid-operation SHALL abandon the access with no further CsrEn pulse; Reset overrides Start and Flush.

Structure
REQ-039 Package csr_pkg SHALL hold:
  - CSR op encodings and main-op codes;
  - CSR address constants;
  - privilege/access field positions;
  - state encodings.
REQ-040 Purely combinational sub-module csr_decode SHALL map Funct3/InstAddr/Rs1Index/RdIndex to CsrOp and Illegal; the FSM SHALL stay in csr_access_ctrl.

Verification
REQ-041 CSRRW, InstAddr=0x340, Rs1Value=0xDEADBEEF, RdIndex=5, CSR model returns 0x12345678 -> CsrOp=00100, CsrData=0xDEADBEEF, Done 4 cycles after Start, RdWe=1, RdValue=0x12345678.
REQ-042 CSRRS, InstAddr=0xC00, Rs1Index=0, RdIndex=3 -> CsrOp=01010, no WRITE state, Done 3 cycles after Start, RdWe=1.
REQ-043 CSRRWI, InstAddr=0xF11, uimm=7 -> Done and Illegal 1 cycle after Start, CsrEn never asserted, RdWe=0.
REQ-044 CSRRCI, InstAddr=0x300, uimm=8, RdIndex=0 -> CsrOp=11100, CsrData=0x00000008, Done 4 cycles after Start, RdWe=0.
REQ-045 Flush asserted in MODIFY, then Start re-issued during the flush cycle -> no Done; second Start ignored; Busy=0 next cycle.
REQ-046 Reset asserted in WRITE -> all outputs 0 next cycle, IDLE, no Done.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared encodings for the CSR access path: op fields, address map, access-field positions, FSM states.
package csr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_MODIFY = 3'd2,
        ST_WRITE  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    // Main op as carried in funct3[1:0]; 00 is not a CSR instruction.
    localparam logic [1:0] MAIN_NONE = 2'b00;
    localparam logic [1:0] MAIN_WR   = 2'b01;
    localparam logic [1:0] MAIN_SET  = 2'b10;
    localparam logic [1:0] MAIN_CLR  = 2'b11;

    localparam logic [1:0] QUAL_RW = 2'b00;
    localparam logic [1:0] QUAL_WO = 2'b01;
    localparam logic [1:0] QUAL_RO = 2'b10;

    typedef struct packed {
        logic       imm;
        logic [1:0] mainOp;
        logic [1:0] qual;
    } csr_op_t;

    localparam int ACC_MSB  = 11;
    localparam int ACC_LSB  = 10;
    localparam int PRIV_MSB = 9;
    localparam int PRIV_LSB = 8;

    localparam logic [1:0] ACC_READONLY  = 2'b11;
    localparam logic [1:0] PRIV_RESERVED = 2'b10;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_MHARTID  = 12'hF11;

endpackage

// File: rtl/csr_decode.sv
// Combinational decode of a SYSTEM CSR instruction into the CSR-file op and an illegal flag.
module csr_decode
    import csr_pkg::*;
(
    input  logic [2:0]  Funct3,
    input  logic [11:8] InstAddr,
    input  logic [4:0]  Rs1Index,
    input  logic [4:0]  RdIndex,
    output csr_op_t     CsrOp,
    output logic        Illegal
);

    always_comb begin
        CsrOp        = '0;
        CsrOp.imm    = Funct3[2];
        CsrOp.mainOp = Funct3[1:0];
        // Writes with rd=x0 skip the read; set/clear with a zero mask skip the write.
        if (Funct3[1:0] == MAIN_WR) begin
            CsrOp.qual = (RdIndex == 5'd0) ? QUAL_WO : QUAL_RW;
        end else begin
            CsrOp.qual = (Rs1Index == 5'd0) ? QUAL_RO : QUAL_RW;
        end

        Illegal = (Funct3[1:0] == MAIN_NONE)
               || ((InstAddr[ACC_MSB:ACC_LSB] == ACC_READONLY) && (CsrOp.qual != QUAL_RO))
               || (InstAddr[PRIV_MSB:PRIV_LSB] == PRIV_RESERVED);
    end

endmodule

// File: rtl/csr_access_ctrl.sv
// Sequences one CSR instruction through the CSR file; Done 3 cycles after Start (read-only),
// 4 (writing), 1 (illegal). Start is dropped while Busy; Flush aborts without Done.
module csr_access_ctrl
    import csr_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Funct3,
    input  logic [11:0] InstAddr,
    input  logic [4:0]  Rs1Index,
    input  logic [31:0] Rs1Value,
    input  logic [4:0]  RdIndex,
    input  logic        Flush,
    output logic        Busy,
    output logic        Done,
    output logic        Illegal,
    output logic        RdWe,
    output logic [31:0] RdValue,
    output logic        CsrEn,
    output logic [4:0]  CsrOp,
    output logic [11:0] CsrAddr,
    output logic [31:0] CsrData,
    input  logic [31:0] CsrRdata
);

    state_t  state, nextState;
    csr_op_t decOp, opQ;
    logic    decIllegal;
    logic    illegalQ;
    logic [4:0] rdIndexQ;
    logic    accept;

    csr_decode uDecode (
        .Funct3   (Funct3),
        .InstAddr (InstAddr[11:8]),
        .Rs1Index (Rs1Index),
        .RdIndex  (RdIndex),
        .CsrOp    (decOp),
        .Illegal  (decIllegal)
    );

    assign accept = (state == ST_IDLE) && Start && !Flush;
    assign CsrOp  = opQ;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= ST_IDLE;
            opQ      <= '0;
            CsrAddr  <= '0;
            CsrData  <= '0;
            RdValue  <= '0;
            illegalQ <= 1'b0;
            rdIndexQ <= '0;
        end else begin
            state <= nextState;
            if (accept) begin
                opQ      <= decOp;
                CsrAddr  <= InstAddr;
                CsrData  <= Funct3[2] ? {27'b0, Rs1Index} : Rs1Value;
                illegalQ <= decIllegal;
                rdIndexQ <= RdIndex;
            end
            if ((state == ST_MODIFY) && !Flush) begin
                RdValue <= CsrRdata;
            end
        end
    end

    always_comb begin
        nextState = state;
        Busy      = (state != ST_IDLE);
        CsrEn     = 1'b0;
        Done      = 1'b0;
        Illegal   = 1'b0;
        RdWe      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) nextState = decIllegal ? ST_FINISH : ST_ISSUE;
            end
            ST_ISSUE: begin
                CsrEn     = !Flush;
                nextState = Flush ? ST_IDLE : ST_MODIFY;
            end
            ST_MODIFY: begin
                if (Flush)                   nextState = ST_IDLE;
                else if (opQ.qual == QUAL_RO) nextState = ST_FINISH;
                else                         nextState = ST_WRITE;
            end
            // A flushed write still occupies its cycle but never reports completion.
            ST_WRITE: begin
                nextState = Flush ? ST_IDLE : ST_FINISH;
            end
            ST_FINISH: begin
                nextState = ST_IDLE;
                Done      = !Flush;
                Illegal   = !Flush && illegalQ;
                RdWe      = !Flush && !illegalQ && (opQ.qual != QUAL_WO) && (rdIndexQ != 5'd0);
            end
            default: nextState = ST_IDLE;
        endcase
        if (Reset) begin
            CsrEn   = 1'b0;
            Done    = 1'b0;
            Illegal = 1'b0;
            RdWe    = 1'b0;
        end
    end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Scoreboard bench for csr_access_ctrl with a one-cycle-latency CSR file model.
module tb_csr_access_ctrl;
    import csr_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset, Start, Flush;
    logic [2:0]  Funct3;
    logic [11:0] InstAddr;
    logic [4:0]  Rs1Index, RdIndex;
    logic [31:0] Rs1Value, CsrRdata;
    logic        Busy, Done, Illegal, RdWe, CsrEn;
    logic [31:0] RdValue, CsrData;
    logic [4:0]  CsrOp;
    logic [11:0] CsrAddr;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          lat;
        logic        ill;
        logic        we;
        logic [31:0] rv;
        logic [4:0]  op;
        logic [31:0] data;
        int          enCnt;
        logic        stable;
    } exp_t;

    exp_t sbq[$];

    logic [2:0]  f3s   [6] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
    logic [11:0] addrs [5] = '{CSR_MSTATUS, CSR_MSCRATCH, CSR_CYCLE, CSR_MTVEC, 12'h200};

    csr_access_ctrl dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Funct3(Funct3), .InstAddr(InstAddr),
        .Rs1Index(Rs1Index), .Rs1Value(Rs1Value), .RdIndex(RdIndex), .Flush(Flush),
        .Busy(Busy), .Done(Done), .Illegal(Illegal), .RdWe(RdWe), .RdValue(RdValue),
        .CsrEn(CsrEn), .CsrOp(CsrOp), .CsrAddr(CsrAddr), .CsrData(CsrData), .CsrRdata(CsrRdata)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] csr_model(input logic [11:0] a);
        case (a)
            12'h340: return 32'h12345678;
            12'hC00: return 32'h00000BEE;
            12'h300: return 32'h00001888;
            default: return {20'hA5A5A, a};
        endcase
    endfunction

    // Data is valid only in the cycle after CsrEn; any other cycle returns poison.
    always @(posedge Clk) CsrRdata <= CsrEn ? csr_model(CsrAddr) : 32'hBAD0BAD0;

    function automatic exp_t mk(input int lat, input logic ill, input logic we, input logic [31:0] rv,
                                input logic [4:0] op, input logic [31:0] data, input int en);
        exp_t e;
        e.lat = lat; e.ill = ill; e.we = we; e.rv = rv; e.op = op; e.data = data; e.enCnt = en; e.stable = 1'b1;
        return e;
    endfunction

    function automatic exp_t expect_of(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r1i,
                                       input logic [31:0] r1v, input logic [4:0] rdi);
        logic [1:0] q;
        logic ill;
        if (f3[1:0] == 2'b01) q = (rdi == 0) ? 2'b01 : 2'b00;
        else                  q = (r1i == 0) ? 2'b10 : 2'b00;
        ill = (f3[1:0] == 2'b00) || (a[11:10] == 2'b11 && q != 2'b10) || (a[9:8] == 2'b10);
        return mk(ill ? 1 : (q == 2'b10 ? 3 : 4), ill, !ill && q != 2'b01 && rdi != 0, csr_model(a),
                  {f3, q}, f3[2] ? {27'b0, r1i} : r1v, ill ? 0 : 1);
    endfunction

    task automatic issue(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r1i,
                         input logic [31:0] r1v, input logic [4:0] rdi);
        Funct3 = f3; InstAddr = a; Rs1Index = r1i; Rs1Value = r1v; RdIndex = rdi; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    // Observes from the first cycle after Start until Done; pokeAt re-pulses Start mid-access.
    task automatic collect(input int pokeAt, output exp_t o);
        logic [43:0] held;
        bit first;
        first = 1'b1;
        held = '0;
        o = mk(-1, 1'bx, 1'bx, 'x, 'x, 'x, 0);
        for (int n = 1; n <= 12; n++) begin
            if (CsrEn) begin o.enCnt++; o.op = CsrOp; o.data = CsrData; end
            if (Busy) begin
                if (!first && {CsrAddr, CsrData} !== held) o.stable = 1'b0;
                held = {CsrAddr, CsrData};
                first = 1'b0;
            end
            if (Done) begin
                o.lat = n; o.ill = Illegal; o.we = RdWe; o.rv = RdValue;
                if (o.enCnt == 0) begin o.op = CsrOp; o.data = CsrData; end
                break;
            end
            if (n == pokeAt) begin
                Start = 1'b1; Funct3 = 3'b001; InstAddr = CSR_MTVEC;
                Rs1Index = 5'd4; Rs1Value = 32'h0BAD0BAD; RdIndex = 5'd9;
            end else begin
                Start = 1'b0;
            end
            @(negedge Clk);
        end
        Start = 1'b0;
    endtask

    task automatic watch(input int n, output int dn, output int en);
        dn = 0; en = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge Clk);
            if (Done || RdWe || Illegal) dn++;
            if (CsrEn) en++;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        checks++;
        if ({Busy, Done, Illegal, RdWe, CsrEn} !== 5'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b want=00000", {Busy, Done, Illegal, RdWe, CsrEn});
        end
        checks++;
        if ({RdValue, CsrOp, CsrAddr, CsrData} !== 81'b0) begin
            failures++; $display("FAIL reset_data got=%h want=0", {RdValue, CsrOp, CsrAddr, CsrData});
        end
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_csrrw();
        exp_t o, e;
        sbq.push_back(mk(4, 1'b0, 1'b1, 32'h12345678, 5'b00100, 32'hDEADBEEF, 1));
        issue(3'b001, CSR_MSCRATCH, 5'd2, 32'hDEADBEEF, 5'd5);
        collect(0, o);
        e = sbq.pop_front();
        checks++; if (o.lat !== e.lat) begin failures++; $display("FAIL rw_latency got=%0d want=%0d", o.lat, e.lat); end
        checks++; if ({o.ill, o.we} !== {e.ill, e.we}) begin failures++; $display("FAIL rw_flags got=%b want=%b", {o.ill, o.we}, {e.ill, e.we}); end
        checks++; if (o.rv !== e.rv) begin failures++; $display("FAIL rw_rdvalue got=%h want=%h", o.rv, e.rv); end
        checks++; if (o.op !== e.op) begin failures++; $display("FAIL rw_op got=%b want=%b", o.op, e.op); end
        checks++; if (o.data !== e.data) begin failures++; $display("FAIL rw_data got=%h want=%h", o.data, e.data); end
        checks++; if (o.enCnt != e.enCnt) begin failures++; $display("FAIL rw_csren got=%0d want=%0d", o.enCnt, e.enCnt); end
        checks++; if (o.stable !== 1'b1) begin failures++; $display("FAIL rw_addr_stable got=%b want=1", o.stable); end
        @(negedge Clk);
    endtask

    task automatic test_csrrs_readonly();
        exp_t o, e;
        sbq.push_back(mk(3, 1'b0, 1'b1, 32'h00000BEE, 5'b01010, 32'h0000FFFF, 1));
        issue(3'b010, CSR_CYCLE, 5'd0, 32'h0000FFFF, 5'd3);
        collect(1, o);
        e = sbq.pop_front();
        checks++; if (o.lat !== e.lat) begin failures++; $display("FAIL rs_latency got=%0d want=%0d", o.lat, e.lat); end
        checks++; if ({o.ill, o.we} !== {e.ill, e.we}) begin failures++; $display("FAIL rs_flags got=%b want=%b", {o.ill, o.we}, {e.ill, e.we}); end
        checks++; if (o.rv !== e.rv) begin failures++; $display("FAIL rs_rdvalue got=%h want=%h", o.rv, e.rv); end
        checks++; if (o.op !== e.op) begin failures++; $display("FAIL rs_op got=%b want=%b", o.op, e.op); end
        checks++; if (o.enCnt != e.enCnt) begin failures++; $display("FAIL rs_csren got=%0d want=%0d", o.enCnt, e.enCnt); end
        @(negedge Clk);
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL rs_no_queue busy=%b want=0", Busy); end
    endtask

    task automatic test_illegal();
        logic [2:0]  tf3 [4] = '{3'b101, 3'b000, 3'b010, 3'b011};
        logic [11:0] tad [4] = '{CSR_MHARTID, CSR_MSTATUS, 12'h200, 12'hC01};
        exp_t o, e;
        for (int i = 0; i < 4; i++) begin
            sbq.push_back(mk(1, 1'b1, 1'b0, '0, '0, '0, 0));
            issue(tf3[i], tad[i], 5'd7, 32'h1, 5'd1);
            collect(0, o);
            e = sbq.pop_front();
            checks++; if (o.lat !== e.lat) begin failures++; $display("FAIL ill_latency[%0d] got=%0d want=%0d", i, o.lat, e.lat); end
            checks++; if ({o.ill, o.we} !== {e.ill, e.we}) begin failures++; $display("FAIL ill_flags[%0d] got=%b want=%b", i, {o.ill, o.we}, {e.ill, e.we}); end
            checks++; if (o.enCnt != e.enCnt) begin failures++; $display("FAIL ill_csren[%0d] got=%0d want=%0d", i, o.enCnt, e.enCnt); end
            @(negedge Clk);
        end
    endtask

    task automatic test_csrrci();
        exp_t o, e;
        sbq.push_back(mk(4, 1'b0, 1'b0, 32'h00001888, 5'b11100, 32'h00000008, 1));
        issue(3'b111, CSR_MSTATUS, 5'd8, 32'hFFFFFFFF, 5'd0);
        collect(0, o);
        e = sbq.pop_front();
        checks++; if (o.lat !== e.lat) begin failures++; $display("FAIL rci_latency got=%0d want=%0d", o.lat, e.lat); end
        checks++; if ({o.ill, o.we} !== {e.ill, e.we}) begin failures++; $display("FAIL rci_flags got=%b want=%b", {o.ill, o.we}, {e.ill, e.we}); end
        checks++; if (o.op !== e.op) begin failures++; $display("FAIL rci_op got=%b want=%b", o.op, e.op); end
        checks++; if (o.data !== e.data) begin failures++; $display("FAIL rci_data got=%h want=%h", o.data, e.data); end
        @(negedge Clk);
    endtask

    task automatic test_flush_modify();
        int dn, en;
        issue(3'b001, CSR_MSCRATCH, 5'd2, 32'h11112222, 5'd5);
        @(negedge Clk);
        Flush = 1'b1; Start = 1'b1; Funct3 = 3'b010; InstAddr = CSR_MSTATUS; Rs1Index = 5'd1; RdIndex = 5'd4;
        @(negedge Clk);
        Flush = 1'b0; Start = 1'b0;
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL flush_mod_busy got=%b want=0", Busy); end
        watch(6, dn, en);
        checks++; if (dn + en != 0) begin failures++; $display("FAIL flush_mod_quiet done=%0d csren=%0d want=0", dn, en); end
    endtask

    task automatic test_flush_write();
        int dn, en;
        issue(3'b001, CSR_MSCRATCH, 5'd2, 32'h33334444, 5'd5);
        repeat (2) @(negedge Clk);
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
        checks++; if ({Busy, Done, RdWe} !== 3'b0) begin failures++; $display("FAIL flush_wr_state got=%b want=000", {Busy, Done, RdWe}); end
        watch(4, dn, en);
        checks++; if (dn != 0) begin failures++; $display("FAIL flush_wr_done got=%0d want=0", dn); end
    endtask

    task automatic test_flush_finish();
        issue(3'b010, CSR_CYCLE, 5'd0, 32'h0, 5'd3);
        @(negedge Clk);
        @(negedge Clk);
        Flush = 1'b1;
        #1;
        checks++; if ({Done, RdWe, Illegal} !== 3'b0) begin failures++; $display("FAIL flush_fin_ro got=%b want=000", {Done, RdWe, Illegal}); end
        @(negedge Clk);
        Flush = 1'b0;
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL flush_fin_busy got=%b want=0", Busy); end
        issue(3'b101, CSR_MHARTID, 5'd7, 32'h0, 5'd1);
        Flush = 1'b1;
        #1;
        checks++; if ({Done, Illegal} !== 2'b0) begin failures++; $display("FAIL flush_fin_ill got=%b want=00", {Done, Illegal}); end
        @(negedge Clk);
        Flush = 1'b0;
    endtask

    task automatic test_flush_start_idle();
        int dn, en;
        Funct3 = 3'b001; InstAddr = CSR_MSCRATCH; Rs1Index = 5'd1; RdIndex = 5'd1; Flush = 1'b1; Start = 1'b1;
        @(negedge Clk);
        Flush = 1'b0; Start = 1'b0;
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL flush_idle_busy got=%b want=0", Busy); end
        watch(3, dn, en);
        checks++; if (en != 0) begin failures++; $display("FAIL flush_idle_csren got=%0d want=0", en); end
    endtask

    task automatic test_reset_mid();
        int dn, en;
        issue(3'b001, CSR_MSCRATCH, 5'd2, 32'h55556666, 5'd5);
        Reset = 1'b1;
        #1;
        checks++; if (CsrEn !== 1'b0) begin failures++; $display("FAIL rst_issue_csren got=%b want=0", CsrEn); end
        @(negedge Clk);
        Reset = 1'b0;
        issue(3'b001, CSR_MSCRATCH, 5'd2, 32'h77778888, 5'd5);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        checks++;
        if ({Busy, Done, Illegal, RdWe, CsrEn, RdValue, CsrOp, CsrAddr, CsrData} !== 86'b0) begin
            failures++; $display("FAIL rst_write_outputs got=%h want=0", {Busy, Done, Illegal, RdWe, CsrEn, RdValue, CsrOp, CsrAddr, CsrData});
        end
        watch(5, dn, en);
        checks++; if (dn + en != 0) begin failures++; $display("FAIL rst_write_quiet done=%0d csren=%0d want=0", dn, en); end
    endtask

    task automatic test_back_to_back();
        exp_t o, e;
        logic [2:0]  f3;
        logic [11:0] a;
        logic [4:0]  r1i, rdi;
        logic [31:0] r1v;
        for (int i = 0; i < 12; i++) begin
            f3  = f3s[$urandom_range(0, 5)];
            a   = addrs[$urandom_range(0, 4)];
            r1i = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rdi = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            r1v = $urandom;
            sbq.push_back(expect_of(f3, a, r1i, r1v, rdi));
            issue(f3, a, r1i, r1v, rdi);
            collect(1, o);
            e = sbq.pop_front();
            checks++; if (o.lat !== e.lat) begin failures++; $display("FAIL b2b_latency[%0d] got=%0d want=%0d", i, o.lat, e.lat); end
            checks++; if ({o.ill, o.we} !== {e.ill, e.we}) begin failures++; $display("FAIL b2b_flags[%0d] got=%b want=%b", i, {o.ill, o.we}, {e.ill, e.we}); end
            checks++; if ({o.op, o.data} !== {e.op, e.data}) begin failures++; $display("FAIL b2b_opdata[%0d] got=%h want=%h", i, {o.op, o.data}, {e.op, e.data}); end
            if (e.we) begin
                checks++; if (o.rv !== e.rv) begin failures++; $display("FAIL b2b_rdvalue[%0d] got=%h want=%h", i, o.rv, e.rv); end
            end
            @(negedge Clk);
            checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL b2b_idle[%0d] busy=%b want=0", i, Busy); end
        end
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Flush = 1'b0; Funct3 = '0; InstAddr = '0;
        Rs1Index = '0; Rs1Value = '0; RdIndex = '0;
        test_reset();
        test_csrrw();
        test_csrrs_readonly();
        test_illegal();
        test_csrrci();
        test_flush_modify();
        test_flush_write();
        test_flush_finish();
        test_flush_start_idle();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
